// File: rtl/alu_pkg.sv
// Shared definitions for the execute-ALU arbiter slice.
// Operation encodings, widths and the requester id type.
package alu_pkg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 4;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_PASS = 4'd8
    } alu_op_e;

    typedef logic req_id_t;

endpackage

// File: rtl/alu.sv
// 64-bit execute ALU with 32-bit word mode (sign-extended result).
// Unsupported operation codes produce zero.
module ALU
    import alu_pkg::*;
(
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_word,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic [DATA_W-1:0] o_result
);

    logic signed [DATA_W-1:0] w_a;
    logic signed [DATA_W-1:0] w_b;
    logic signed [31:0]       w_a32;
    logic signed [31:0]       w_b32;
    logic [DATA_W-1:0]        w_r64;
    logic [31:0]              w_r32;

    assign w_a   = i_op1;
    assign w_b   = i_op2;
    assign w_a32 = i_op1[31:0];
    assign w_b32 = i_op2[31:0];

    always_comb begin
        w_r64 = '0;
        w_r32 = '0;
        case (i_ctrl)
            ALU_ADD: begin
                w_r64 = w_a + w_b;
                w_r32 = w_a32 + w_b32;
            end
            ALU_SUB: begin
                w_r64 = w_a - w_b;
                w_r32 = w_a32 - w_b32;
            end
            ALU_AND: begin
                w_r64 = w_a & w_b;
                w_r32 = w_a32 & w_b32;
            end
            ALU_OR: begin
                w_r64 = w_a | w_b;
                w_r32 = w_a32 | w_b32;
            end
            ALU_XOR: begin
                w_r64 = w_a ^ w_b;
                w_r32 = w_a32 ^ w_b32;
            end
            ALU_SLT: begin
                w_r64 = DATA_W'(w_a < w_b);
                w_r32 = 32'(w_a32 < w_b32);
            end
            ALU_SLL: begin
                w_r64 = w_a << i_op2[5:0];
                w_r32 = w_a32 << i_op2[4:0];
            end
            ALU_SRA: begin
                w_r64 = w_a >>> i_op2[5:0];
                w_r32 = w_a32 >>> i_op2[4:0];
            end
            ALU_PASS: begin
                w_r64 = w_b;
                w_r32 = w_b32;
            end
            default: begin
                w_r64 = '0;
                w_r32 = '0;
            end
        endcase
    end

    assign o_result = i_word ? {{(DATA_W-32){w_r32[31]}}, w_r32} : w_r64;

endmodule

// File: rtl/alu_arb_pick.sv
// One-hot grant picker for the two ALU requesters.
// ALU_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module alu_arb_pick
    import alu_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_id_t    i_last_id,
    output logic [1:0] o_grant
);

`ifdef ALU_ARB_RR_EN
    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = i_last_id ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_id;

    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around the shared execute ALU: issue stage S1,
// response stage S2. Round-robin when ALU_ARB_RR_EN is defined.
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int CTRL_W = alu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req0_word,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic              req1_word,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_data
);

    import alu_pkg::*;

    logic              r_s1_valid;
    req_id_t           r_s1_id;
    logic [DATA_W-1:0] r_s1_op1;
    logic [DATA_W-1:0] r_s1_op2;
    logic [CTRL_W-1:0] r_s1_ctrl;
    logic              r_s1_word;
    logic              r_s2_valid;
    req_id_t           r_s2_id;
    logic [DATA_W-1:0] r_s2_data;
    req_id_t           r_last_id;

    logic [1:0]        w_grant;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [DATA_W-1:0] w_alu_res;

    alu_arb_pick u_pick (
        .i_valid   ({req1_valid, req0_valid}),
        .i_last_id (r_last_id),
        .o_grant   (w_grant)
    );

    ALU u_alu (
        .i_ctrl   (r_s1_ctrl),
        .i_word   (r_s1_word),
        .i_op1    (r_s1_op1),
        .i_op2    (r_s1_op2),
        .o_result (w_alu_res)
    );

    // S2 frees when empty or its owner takes the result this edge.
    assign w_s2_adv = !r_s2_valid || (r_s2_id ? resp1_ready : resp0_ready);
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    assign req0_ready  = w_grant[0] && w_s1_adv;
    assign req1_ready  = w_grant[1] && w_s1_adv;
    assign resp0_valid = r_s2_valid && (r_s2_id == 1'b0);
    assign resp1_valid = r_s2_valid && (r_s2_id == 1'b1);
    assign resp_data   = r_s2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_op1   <= '0;
            r_s1_op2   <= '0;
            r_s1_ctrl  <= '0;
            r_s1_word  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= 1'b0;
            r_s2_data  <= '0;
            r_last_id  <= 1'b1;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= |w_grant;
                if (|w_grant) begin
                    r_s1_id   <= w_grant[1];
                    r_s1_op1  <= w_grant[1] ? req1_op1 : req0_op1;
                    r_s1_op2  <= w_grant[1] ? req1_op2 : req0_op2;
                    r_s1_ctrl <= w_grant[1] ? req1_ctrl : req0_ctrl;
                    r_s1_word <= w_grant[1] ? req1_word : req0_word;
                    r_last_id <= w_grant[1];
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_id    <= r_s1_id;
                r_s2_data  <= w_alu_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a cycle model of the two-stage pipe.
// Honors ALU_ARB_RR_EN the same way as the design.
module tb_alu_arbiter;

    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
    logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic        req0_word = 0, req1_word = 0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1, resp1_ready = 1;
    logic [63:0] resp_data;

    int checks = 0;
    int failures = 0;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_ctrl(req0_ctrl), .req0_word(req0_word),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_ctrl(req1_ctrl), .req1_word(req1_word),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, r;
        int     a32, b32, r32;
        sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0];
        r = 0; r32 = 0;
        case (c)
            4'd0: begin r = sa + sb; r32 = a32 + b32; end
            4'd1: begin r = sa - sb; r32 = a32 - b32; end
            4'd2: begin r = sa & sb; r32 = a32 & b32; end
            4'd3: begin r = sa | sb; r32 = a32 | b32; end
            4'd4: begin r = sa ^ sb; r32 = a32 ^ b32; end
            4'd5: begin r = (sa < sb) ? 1 : 0; r32 = (a32 < b32) ? 1 : 0; end
            4'd6: begin r = sa << b[5:0]; r32 = a32 << b[4:0]; end
            4'd7: begin r = sa >>> b[5:0]; r32 = a32 >>> b[4:0]; end
            4'd8: begin r = sb; r32 = b32; end
            default: begin r = 0; r32 = 0; end
        endcase
        if (w) r = longint'(r32);
        return r;
    endfunction

    // Model state as it will be after the next rising edge.
    logic        m_on = 1'b0;
    logic        m1v, m1id, m2v, m2id, m_last;
    logic [63:0] m1d, m2d;
    logic [1:0]  mg;
    logic        ms2a, ms1a;

    always @(negedge clk) begin
        if (rst) begin
            m_on = 1'b1;
            m1v = 0; m1id = 0; m1d = 0;
            m2v = 0; m2id = 0; m2d = 0;
            m_last = 1'b1;
        end else if (m_on) begin
            mg = {req1_valid, req0_valid};
            if (req0_valid && req1_valid)
                mg = (RR && m_last == 1'b0) ? 2'b10 : 2'b01;
            ms2a = !m2v || (m2id ? resp1_ready : resp0_ready);
            ms1a = !m1v || ms2a;
            chk("m_req0_ready", req0_ready, mg[0] && ms1a);
            chk("m_req1_ready", req1_ready, mg[1] && ms1a);
            chk("m_resp0_valid", resp0_valid, m2v && !m2id);
            chk("m_resp1_valid", resp1_valid, m2v && m2id);
            if (m2v) chk("m_resp_data", resp_data, m2d);
            if (ms2a) begin
                m2v = m1v; m2id = m1id; m2d = m1d;
            end
            if (ms1a) begin
                m1v = |mg;
                if (mg[1]) begin
                    m1id = 1; m_last = 1;
                    m1d = ref_alu(req1_ctrl, req1_word, req1_op1, req1_op2);
                end else if (mg[0]) begin
                    m1id = 0; m_last = 0;
                    m1d = ref_alu(req0_ctrl, req0_word, req0_op1, req0_op2);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] held;
    int          n;
    logic        eid;

    initial begin
        cyc(); cyc();
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_valid", resp1_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        rst = 0;

        // ADD 5+7 on requester 0
        req0_valid = 1; req0_ctrl = 4'd0; req0_word = 0; req0_op1 = 5; req0_op2 = 7;
        cyc();
        req0_valid = 0;
        chk("add_not_early", resp0_valid, 0);
        cyc();
        chk("add_valid", resp0_valid, 1);
        chk("add_data", resp_data, 64'd12);
        chk("add_resp1_quiet", resp1_valid, 0);
        cyc();

        // SUB word 0-1 on requester 1
        req1_valid = 1; req1_ctrl = 4'd1; req1_word = 1; req1_op1 = 0; req1_op2 = 1;
        cyc();
        req1_valid = 0;
        cyc();
        chk("subw_valid", resp1_valid, 1);
        chk("subw_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();

        // SRA -16 >>> 2 on requester 0
        req0_valid = 1; req0_ctrl = 4'd7; req0_word = 0;
        req0_op1 = 64'hFFFF_FFFF_FFFF_FFF0; req0_op2 = 2;
        cyc();
        req0_valid = 0;
        cyc();
        chk("sra_valid", resp0_valid, 1);
        chk("sra_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();

        // Both valid continuously: last winner was 0
        req0_valid = 1; req0_ctrl = 4'd0; req0_word = 0; req0_op1 = 1; req0_op2 = 1;
        req1_valid = 1; req1_ctrl = 4'd0; req1_word = 0; req1_op1 = 2; req1_op2 = 2;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i >= 2) begin
                n = i - 1;
                eid = RR ? n[0] : 1'b0;
                chk("alt_resp0", resp0_valid, !eid);
                chk("alt_resp1", resp1_valid, eid);
                chk("alt_data", resp_data, eid ? 64'd4 : 64'd2);
            end
        end
        req0_valid = 0; req1_valid = 0;
        cyc(); cyc(); cyc();

        // Stall requester 0's response with both stages full
        resp0_ready = 0;
        req0_valid = 1; req0_ctrl = 4'd0; req0_op1 = 10; req0_op2 = 20;
        cyc(); cyc();
        chk("stall_full_ready", req0_ready, 0);
        chk("stall_full_valid", resp0_valid, 1);
        held = resp_data;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_ready", req0_ready, 0);
            chk("stall_data", resp_data, 64'd30);
            chk("stall_stable", resp_data, held);
        end
        resp0_ready = 1;
        #1;
        chk("release_ready", req0_ready, 1);
        cyc();
        chk("release_drain", resp0_valid, 1);
        chk("release_accept", req0_ready, 1);
        req0_valid = 0;
        cyc(); cyc(); cyc();

        // Reset with operations in flight
        resp0_ready = 0;
        req0_valid = 1; req0_op1 = 3; req0_op2 = 4;
        cyc(); cyc();
        chk("pre_rst_valid", resp0_valid, 1);
        rst = 1; req0_valid = 0;
        cyc();
        chk("midrst_resp0", resp0_valid, 0);
        chk("midrst_resp1", resp1_valid, 0);
        chk("midrst_data", resp_data, 0);
        rst = 0; resp0_ready = 1; resp1_ready = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("post_rst_g0", req0_ready, 1);
        chk("post_rst_g1", req1_ready, 0);
        cyc();
        chk("post_rst_next_g1", req1_ready, RR);
        req0_valid = 0; req1_valid = 0;
        cyc(); cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
